mips_mc_controller_p: RTL and testbench
=======================================

// Module: mips_mc_controller_p
// PURPOSE
//  Parametrised multicycle MIPS-subset control FSM.
//  - Generalises the fixed 8-bit controller to WIDTH-bit datapaths: the 32-bit instruction is fetched in 32/WIDTH beats.
//  - Adds a memory ready handshake, addi support and illegal-opcode detection.
//  - Sits between the instruction register opcode field and the datapath mux/enable controls.
// PARAMETERS
//  WIDTH          8  datapath width (8, 16 or 32); NBEATS = 32/WIDTH fetch beats
//  MEM_HANDSHAKE  1  1: stall memory states on memready; 0: memready treated as constant 1
// PORTS
//  clk       in   1       rising-edge clock
//  reset     in   1       synchronous, active-high
//  op        in   6       opcode from instruction register
//  memready  in   1       memory access completes this cycle
//  alusrca   out  1       ALU A: 0 = PC, 1 = register A
//  alusrcb   out  2       ALU B: 00 = B, 01 = constant 1 beat, 10 = imm, 11 = imm<<2
//  aluop     out  2       00 add, 01 sub, 10 funct-decoded
//  branch    out  1       conditional PC write (datapath ANDs with zero)
//  iord      out  1       memory address: 0 = PC, 1 = ALUOut
//  irwrite   out  NBEATS  one-hot IR beat write enable
//  memread   out  1       memory read request
//  memwrite  out  1       memory write request
//  memtoreg  out  1       register write data: 1 = MDR, 0 = ALUOut
//  pcwrite   out  1       unconditional PC write
//  pcsource  out  2       00 ALU, 01 ALUOut, 10 jump target
//  regwrite  out  1       register file write
//  regdst    out  1       write register: 1 = rd, 0 = rt
//  illegal   out  1       one-cycle pulse on unknown opcode in DECODE
//  state     out  4       current state encoding (debug)
// BEHAVIOUR
//  States and encodings:
//   FETCH=0 DECODE=1 MEMADR=2 LBRD=3 LBWR=4 SBWR=5 RTYPEEX=6 RTYPEWR=7 BEQEX=8 JEX=9 ADDIEX=10 ADDIWR=11.
//  Moore outputs: decoded from the registered state plus the beat counter fcnt. Every output not listed below is 0.
//  FETCH
//   - Outputs: memread=1, alusrcb=01, aluop=00.
//   - When memready=1: irwrite[fcnt]=1 and pcwrite=1.
//   - Transition on memready=1: fcnt++; at fcnt==NBEATS-1, fcnt wraps to 0 and next state is DECODE. memready=0 holds state and fcnt.
//  DECODE: alusrcb=11. Next state by op:
//   - 100000 / 101000 -> MEMADR
//   - 000000 -> RTYPEEX
//   - 000100 -> BEQEX
//   - 000010 -> JEX
//   - 001000 -> ADDIEX
//   - any other op -> FETCH with illegal=1 for that cycle only
//  MEMADR: alusrca=1, alusrcb=10. Next state: op==100000 -> LBRD, else SBWR.
//  LBRD: memread=1, iord=1; holds until memready=1, then LBWR.
//  LBWR: regwrite=1, memtoreg=1; next state FETCH.
//  SBWR: memwrite=1, iord=1, held while memready=0; next state FETCH on memready=1.
//  RTYPEEX: alusrca=1, aluop=10; next state RTYPEWR.
//  RTYPEWR: regdst=1, regwrite=1; next state FETCH.
//  BEQEX: alusrca=1, aluop=01, branch=1, pcsource=01; next state FETCH.
//  JEX: pcwrite=1, pcsource=10; next state FETCH.
//  ADDIEX: alusrca=1, alusrcb=10; next state ADDIWR.
//  ADDIWR: regwrite=1, regdst=0, memtoreg=0; next state FETCH.
//  Reset
//   - A clock edge with reset=1 sets state=FETCH and fcnt=0 from any state, including mid-fetch or mid-store.
//   - While reset=1, irwrite, pcwrite, regwrite and memwrite are forced to 0.
//   - First cycle after reset: memread=1, alusrcb=01, irwrite[0]=memready, pcwrite=memready, all other outputs 0.
//  op is sampled only in DECODE and MEMADR; op changes in other states have no effect.
//  Latency with memready=1, WIDTH=8 (total cycles including fetch):
//   - lb 8; sb 7; R-type 7; addi 7; beq 6; j 6.
//   - Each memready=0 cycle in a memory state adds one cycle.
//  WIDTH=32: NBEATS=1, irwrite is 1 bit, and FETCH lasts one cycle when ready.
//  Any unused state encoding (12-15) returns to FETCH on the next edge, with all outputs 0.
// TESTING
//  1. WIDTH=8, memready=1, op=100000 -> states 0,0,0,0,1,2,3,4; irwrite 0001,0010,0100,1000; memtoreg=regwrite=1 in state 4.
//  2. memready low for 3 cycles in FETCH beat 2 -> state and fcnt held, irwrite=0, pcwrite=0 during the stall; beat 2 write occurs on the ready cycle.
//  3. op=101000 with memready low 2 cycles in SBWR -> memwrite=1 and iord=1 held 3 cycles, then FETCH.
//  4. op=111111 -> DECODE asserts illegal=1 for exactly one cycle; next state is FETCH; regwrite, memwrite and pcwrite never assert.
//  5. reset pulsed during FETCH beat 3 -> next state is FETCH with fcnt=0; irwrite=0 and pcwrite=0 during reset.
//  6. WIDTH=32: op=000010 -> states 0,1,9,0; pcsource=10 and pcwrite=1 in state 9; op=001000 -> states 0,1,10,11 with regdst=0.

Source files
------------

// File: rtl/mips_mc_controller_p.sv
// rtl/mips_mc_controller_p.sv - multicycle MIPS-subset control FSM with WIDTH-bit beat-wise instruction fetch
module mips_mc_controller_p #(
    parameter int WIDTH         = 8,
    parameter bit MEM_HANDSHAKE = 1'b1,
    localparam int NBEATS       = 32 / WIDTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [5:0]        op,
    input  logic              memready,
    output logic              alusrca,
    output logic [1:0]        alusrcb,
    output logic [1:0]        aluop,
    output logic              branch,
    output logic              iord,
    output logic [NBEATS-1:0] irwrite,
    output logic              memread,
    output logic              memwrite,
    output logic              memtoreg,
    output logic              pcwrite,
    output logic [1:0]        pcsource,
    output logic              regwrite,
    output logic              regdst,
    output logic              illegal,
    output logic [3:0]        state
);

    localparam int FW = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam logic [FW-1:0] LAST_BEAT = FW'(NBEATS - 1);

    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_SB    = 6'b101000;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        LBRD    = 4'd3,
        LBWR    = 4'd4,
        SBWR    = 4'd5,
        RTYPEEX = 4'd6,
        RTYPEWR = 4'd7,
        BEQEX   = 4'd8,
        JEX     = 4'd9,
        ADDIEX  = 4'd10,
        ADDIWR  = 4'd11
    } state_t;

    state_t        cur;
    logic [FW-1:0] fcnt;
    logic          rdy;

    // Without the handshake every memory access is assumed to finish in one cycle.
    assign rdy   = memready | !MEM_HANDSHAKE;
    assign state = cur;

    always_ff @(posedge clk) begin
        if (reset) begin
            cur  <= FETCH;
            fcnt <= '0;
        end else begin
            case (cur)
                FETCH: begin
                    if (rdy) begin
                        if (fcnt == LAST_BEAT) begin
                            fcnt <= '0;
                            cur  <= DECODE;
                        end else begin
                            fcnt <= fcnt + 1'b1;
                        end
                    end
                end
                DECODE: begin
                    case (op)
                        OP_LB, OP_SB: cur <= MEMADR;
                        OP_RTYPE:     cur <= RTYPEEX;
                        OP_BEQ:       cur <= BEQEX;
                        OP_J:         cur <= JEX;
                        OP_ADDI:      cur <= ADDIEX;
                        default:      cur <= FETCH;
                    endcase
                end
                MEMADR:  cur <= (op == OP_LB) ? LBRD : SBWR;
                LBRD:    if (rdy) cur <= LBWR;
                LBWR:    cur <= FETCH;
                SBWR:    if (rdy) cur <= FETCH;
                RTYPEEX: cur <= RTYPEWR;
                RTYPEWR: cur <= FETCH;
                BEQEX:   cur <= FETCH;
                JEX:     cur <= FETCH;
                ADDIEX:  cur <= ADDIWR;
                ADDIWR:  cur <= FETCH;
                default: cur <= FETCH;
            endcase
        end
    end

    always_comb begin
        alusrca  = 1'b0;
        alusrcb  = 2'b00;
        aluop    = 2'b00;
        branch   = 1'b0;
        iord     = 1'b0;
        irwrite  = '0;
        memread  = 1'b0;
        memwrite = 1'b0;
        memtoreg = 1'b0;
        pcwrite  = 1'b0;
        pcsource = 2'b00;
        regwrite = 1'b0;
        regdst   = 1'b0;
        illegal  = 1'b0;
        case (cur)
            FETCH: begin
                memread = 1'b1;
                alusrcb = 2'b01;
                if (rdy) begin
                    irwrite[fcnt] = 1'b1;
                    pcwrite       = 1'b1;
                end
            end
            DECODE: begin
                alusrcb = 2'b11;
                case (op)
                    OP_LB, OP_SB, OP_RTYPE, OP_BEQ, OP_J, OP_ADDI: illegal = 1'b0;
                    default:                                       illegal = 1'b1;
                endcase
            end
            MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            LBRD: begin
                memread = 1'b1;
                iord    = 1'b1;
            end
            LBWR: begin
                regwrite = 1'b1;
                memtoreg = 1'b1;
            end
            SBWR: begin
                memwrite = 1'b1;
                iord     = 1'b1;
            end
            RTYPEEX: begin
                alusrca = 1'b1;
                aluop   = 2'b10;
            end
            RTYPEWR: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
            end
            BEQEX: begin
                alusrca  = 1'b1;
                aluop    = 2'b01;
                branch   = 1'b1;
                pcsource = 2'b01;
            end
            JEX: begin
                pcwrite  = 1'b1;
                pcsource = 2'b10;
            end
            ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            ADDIWR: regwrite = 1'b1;
            default: ;
        endcase
        // Architectural write strobes must never fire while reset is held.
        if (reset) begin
            irwrite  = '0;
            pcwrite  = 1'b0;
            regwrite = 1'b0;
            memwrite = 1'b0;
        end
    end

endmodule

// File: tb/tb_mips_mc_controller_p.sv
// tb/tb_mips_mc_controller_p.sv - table-driven bench for mips_mc_controller_p at WIDTH=8 and WIDTH=32
module tb_mips_mc_controller_p;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst8 = 1'b1, mr8 = 1'b1;
    logic [5:0] op8 = 6'd0;
    logic       rst32 = 1'b1, mr32 = 1'b0;
    logic [5:0] op32 = 6'd0;

    logic       a8, br8, iord8, mrd8, mwr8, m2r8, pcw8, rw8, rd8, ill8;
    logic [1:0] b8, alu8, pcs8;
    logic [3:0] ir8, st8;

    logic       a32, br32, iord32, mrd32, mwr32, m2r32, pcw32, rw32, rd32, ill32;
    logic [1:0] b32, alu32, pcs32;
    logic [0:0] ir32;
    logic [3:0] st32;

    mips_mc_controller_p #(.WIDTH(8), .MEM_HANDSHAKE(1'b1)) u8 (
        .clk(clk), .reset(rst8), .op(op8), .memready(mr8),
        .alusrca(a8), .alusrcb(b8), .aluop(alu8), .branch(br8), .iord(iord8),
        .irwrite(ir8), .memread(mrd8), .memwrite(mwr8), .memtoreg(m2r8),
        .pcwrite(pcw8), .pcsource(pcs8), .regwrite(rw8), .regdst(rd8),
        .illegal(ill8), .state(st8)
    );

    mips_mc_controller_p #(.WIDTH(32), .MEM_HANDSHAKE(1'b0)) u32 (
        .clk(clk), .reset(rst32), .op(op32), .memready(mr32),
        .alusrca(a32), .alusrcb(b32), .aluop(alu32), .branch(br32), .iord(iord32),
        .irwrite(ir32), .memread(mrd32), .memwrite(mwr32), .memtoreg(m2r32),
        .pcwrite(pcw32), .pcsource(pcs32), .regwrite(rw32), .regdst(rd32),
        .illegal(ill32), .state(st32)
    );

    // {alusrca, alusrcb, aluop, branch, iord, memread, memwrite, memtoreg, pcwrite, pcsource, regwrite, regdst, illegal}
    logic [15:0] ctl8, ctl32;
    assign ctl8  = {a8, b8, alu8, br8, iord8, mrd8, mwr8, m2r8, pcw8, pcs8, rw8, rd8, ill8};
    assign ctl32 = {a32, b32, alu32, br32, iord32, mrd32, mwr32, m2r32, pcw32, pcs32, rw32, rd32, ill32};

    localparam logic [15:0] C_FR   = 16'h2120; // FETCH, memory ready
    localparam logic [15:0] C_FS   = 16'h2100; // FETCH stalled or in reset
    localparam logic [15:0] C_DEC  = 16'h6000;
    localparam logic [15:0] C_ILL  = 16'h6001;
    localparam logic [15:0] C_MADR = 16'hC000;
    localparam logic [15:0] C_LBRD = 16'h0300;
    localparam logic [15:0] C_LBWR = 16'h0044;
    localparam logic [15:0] C_SBWR = 16'h0280;
    localparam logic [15:0] C_REX  = 16'h9000;
    localparam logic [15:0] C_RWR  = 16'h0006;
    localparam logic [15:0] C_BEQ  = 16'h8C08;
    localparam logic [15:0] C_JEX  = 16'h0030;
    localparam logic [15:0] C_AEX  = 16'hC000;
    localparam logic [15:0] C_AWR  = 16'h0004;

    typedef struct {
        bit         w32;
        logic       rst;
        logic [5:0] op;
        logic       mr;
        logic [3:0] est;
        logic [3:0] eir;
        logic [15:0] ectl;
    } vec_t;

    vec_t vecs[$];
    int   tests = 0;
    int   fails = 0;

    task automatic add(input bit w, input logic r, input logic [5:0] o, input logic m,
                       input logic [3:0] s, input logic [3:0] i, input logic [15:0] c);
        vec_t v;
        v.w32 = w; v.rst = r; v.op = o; v.mr = m; v.est = s; v.eir = i; v.ectl = c;
        vecs.push_back(v);
    endtask

    task automatic chk(input int idx, input string what, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL vec%0d %s: got %h expected %h", idx, what, act, exp);
        end
    endtask

    initial begin
        // lb with memready=1, preceded by a reset cycle
        add(0, 1, 6'h20, 1, 0, 4'h0, C_FS);
        add(0, 0, 6'h20, 1, 0, 4'h1, C_FR);
        add(0, 0, 6'h20, 1, 0, 4'h2, C_FR);
        add(0, 0, 6'h20, 1, 0, 4'h4, C_FR);
        add(0, 0, 6'h20, 1, 0, 4'h8, C_FR);
        add(0, 0, 6'h20, 1, 1, 4'h0, C_DEC);
        add(0, 0, 6'h20, 1, 2, 4'h0, C_MADR);
        add(0, 0, 6'h20, 1, 3, 4'h0, C_LBRD);
        add(0, 0, 6'h20, 1, 4, 4'h0, C_LBWR);
        // sb with a 3-cycle stall in fetch beat 2 and a 2-cycle stall in SBWR
        add(0, 0, 6'h28, 1, 0, 4'h1, C_FR);
        add(0, 0, 6'h28, 1, 0, 4'h2, C_FR);
        add(0, 0, 6'h28, 0, 0, 4'h0, C_FS);
        add(0, 0, 6'h28, 0, 0, 4'h0, C_FS);
        add(0, 0, 6'h28, 0, 0, 4'h0, C_FS);
        add(0, 0, 6'h28, 1, 0, 4'h4, C_FR);
        add(0, 0, 6'h28, 1, 0, 4'h8, C_FR);
        add(0, 0, 6'h28, 1, 1, 4'h0, C_DEC);
        add(0, 0, 6'h28, 1, 2, 4'h0, C_MADR);
        add(0, 0, 6'h28, 0, 5, 4'h0, C_SBWR);
        add(0, 0, 6'h28, 0, 5, 4'h0, C_SBWR);
        add(0, 0, 6'h28, 1, 5, 4'h0, C_SBWR);
        // illegal opcode
        add(0, 0, 6'h3F, 1, 0, 4'h1, C_FR);
        add(0, 0, 6'h3F, 1, 0, 4'h2, C_FR);
        add(0, 0, 6'h3F, 1, 0, 4'h4, C_FR);
        add(0, 0, 6'h3F, 1, 0, 4'h8, C_FR);
        add(0, 0, 6'h3F, 1, 1, 4'h0, C_ILL);
        add(0, 0, 6'h00, 1, 0, 4'h1, C_FR);
        // R-type; op changes during RTYPEEX must be ignored
        add(0, 0, 6'h00, 1, 0, 4'h2, C_FR);
        add(0, 0, 6'h00, 1, 0, 4'h4, C_FR);
        add(0, 0, 6'h00, 1, 0, 4'h8, C_FR);
        add(0, 0, 6'h00, 1, 1, 4'h0, C_DEC);
        add(0, 0, 6'h3F, 1, 6, 4'h0, C_REX);
        add(0, 0, 6'h3F, 1, 7, 4'h0, C_RWR);
        // beq
        add(0, 0, 6'h04, 1, 0, 4'h1, C_FR);
        add(0, 0, 6'h04, 1, 0, 4'h2, C_FR);
        add(0, 0, 6'h04, 1, 0, 4'h4, C_FR);
        add(0, 0, 6'h04, 1, 0, 4'h8, C_FR);
        add(0, 0, 6'h04, 1, 1, 4'h0, C_DEC);
        add(0, 0, 6'h04, 1, 8, 4'h0, C_BEQ);
        // reset pulsed in fetch beat 3, then fetch restarts at beat 0
        add(0, 0, 6'h04, 1, 0, 4'h1, C_FR);
        add(0, 0, 6'h04, 1, 0, 4'h2, C_FR);
        add(0, 0, 6'h04, 1, 0, 4'h4, C_FR);
        add(0, 1, 6'h04, 1, 0, 4'h0, C_FS);
        add(0, 0, 6'h04, 1, 0, 4'h1, C_FR);
        add(0, 0, 6'h04, 1, 0, 4'h2, C_FR);
        // WIDTH=32 without handshake (memready held low): j then addi
        add(1, 1, 6'h02, 0, 0, 4'h0, C_FS);
        add(1, 0, 6'h02, 0, 0, 4'h1, C_FR);
        add(1, 0, 6'h02, 0, 1, 4'h0, C_DEC);
        add(1, 0, 6'h02, 0, 9, 4'h0, C_JEX);
        add(1, 0, 6'h08, 0, 0, 4'h1, C_FR);
        add(1, 0, 6'h08, 0, 1, 4'h0, C_DEC);
        add(1, 0, 6'h08, 0, 10, 4'h0, C_AEX);
        add(1, 0, 6'h08, 0, 11, 4'h0, C_AWR);
        add(1, 0, 6'h08, 0, 0, 4'h1, C_FR);

        repeat (2) @(posedge clk);
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            if (vecs[i].w32) begin
                rst32 = vecs[i].rst; op32 = vecs[i].op; mr32 = vecs[i].mr;
            end else begin
                rst8 = vecs[i].rst; op8 = vecs[i].op; mr8 = vecs[i].mr;
            end
            #1;
            if (vecs[i].w32) begin
                chk(i, "state", {12'd0, st32}, {12'd0, vecs[i].est});
                chk(i, "irwrite", {15'd0, ir32}, {12'd0, vecs[i].eir});
                chk(i, "controls", ctl32, vecs[i].ectl);
            end else begin
                chk(i, "state", {12'd0, st8}, {12'd0, vecs[i].est});
                chk(i, "irwrite", {12'd0, ir8}, {12'd0, vecs[i].eir});
                chk(i, "controls", ctl8, vecs[i].ectl);
            end
        end
        // After the addi row the 32-bit instance is in FETCH; the next edge must go to DECODE.
        @(negedge clk);
        #1;
        chk(vecs.size(), "w32 fetch->decode", {12'd0, st32}, 16'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
